// File: rtl/byte_unpacker_if.sv
// Byte-in / nibble-out handshake bundle for byte_unpacker.
// master: upstream/downstream driver side; slave: the unpacker itself.
interface byte_unpacker_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_nib;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_nib, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_nib, out_valid, out_last
  );
endinterface

// File: rtl/byte_unpacker.sv
// byte_unpacker: buffers up to two bytes and emits each as two nibbles.
// Nibble order: high nibble first by default; define UNPACK_LOW_FIRST_EN
// to emit the low nibble first.
// All outputs come from registered state only; a full buffer never
// accepts a byte, even on an edge where the head byte is popped.
module byte_unpacker (
  input  logic           clk,
  input  logic           rst,
  byte_unpacker_if.slave bus,
  output logic           full,
  output logic           empty,
  output logic [7:0]     bytes_done
);

  localparam int DATA_W = 8;
  localparam int NIB_W  = DATA_W / 2;

  logic [DATA_W-1:0] mem [2];
  logic [1:0]        count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              phase;
  logic              push;
  logic              xfer;
  logic              pop;

  // Phase 0 selects the first nibble of the head byte, phase 1 the second.
  function automatic logic [NIB_W-1:0] sel_nib(input logic [DATA_W-1:0] b,
                                               input logic ph);
`ifdef UNPACK_LOW_FIRST_EN
    sel_nib = ph ? b[DATA_W-1:NIB_W] : b[NIB_W-1:0];
`else
    sel_nib = ph ? b[NIB_W-1:0] : b[DATA_W-1:NIB_W];
`endif
  endfunction

  assign bus.in_ready  = (count < 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_last  = phase;
  assign bus.out_nib   = sel_nib(mem[rd_ptr], phase);
  assign full          = (count == 2'd2);
  assign empty         = (count == 2'd0);

  assign push = bus.in_valid && bus.in_ready;
  assign xfer = bus.out_valid && bus.out_ready;
  assign pop  = xfer && phase;

  // Storage entries and write pointer: capture accepted bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
    end else if (push) begin
      mem[wr_ptr] <= bus.in_data;
      wr_ptr      <= ~wr_ptr;
    end
  end

  // Read side: nibble phase, head pointer and emitted-byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= 1'b0;
      rd_ptr     <= 1'b0;
      bytes_done <= '0;
    end else begin
      if (xfer) begin
        phase <= ~phase;
      end
      if (pop) begin
        rd_ptr     <= ~rd_ptr;
        bytes_done <= bytes_done + 8'd1;
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_unpacker.sv
// Testbench for byte_unpacker. The reference model keeps a queue of
// nibbles still owed downstream; occupancy, out_last and bytes_done are
// derived from that queue and from the number of nibbles handed out.
module tb_byte_unpacker;

  logic       clk;
  logic       rst;
  logic       full;
  logic       empty;
  logic [7:0] bytes_done;

  byte_unpacker_if bus();

  byte_unpacker dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .full       (full),
    .empty      (empty),
    .bytes_done (bytes_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] nib_q[$];
  logic [7:0] m_done;

  function automatic logic [3:0] first_nib(input logic [7:0] d);
`ifdef UNPACK_LOW_FIRST_EN
    return d[3:0];
`else
    return d[7:4];
`endif
  endfunction

  function automatic logic [3:0] second_nib(input logic [7:0] d);
`ifdef UNPACK_LOW_FIRST_EN
    return d[7:4];
`else
    return d[3:0];
`endif
  endfunction

  function automatic int stored();
    return (nib_q.size() + 1) / 2;
  endfunction

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    bit         do_push;
    bit         do_pop;
    logic [7:0] d;
    do_push = bus.in_valid && (stored() < 2);
    do_pop  = (nib_q.size() > 0) && bus.out_ready;
    d       = bus.in_data;
    @(posedge clk);
    if (rst) begin
      nib_q.delete();
      m_done = 8'd0;
    end else begin
      if (do_pop) begin
        if (nib_q.size() % 2 == 1) m_done = m_done + 8'd1;
        void'(nib_q.pop_front());
      end
      if (do_push) begin
        nib_q.push_back(first_nib(d));
        nib_q.push_back(second_nib(d));
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    do_reset();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_nib !== 4'h0) begin errors++; $display("FAIL reset_out_nib got %h want 0", bus.out_nib); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (bytes_done !== 8'd0) begin errors++; $display("FAIL reset_bytes_done got %0d want 0", bytes_done); end
  endtask

  task automatic test_single_byte();
    logic [7:0] d;
    d = 8'hA5;
    bus.in_data   = d;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_nib !== first_nib(d)) begin errors++; $display("FAIL single_nib0 got %h want %h", bus.out_nib, first_nib(d)); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL single_last0 got %b want 0", bus.out_last); end
    tick();
    checks++; if (bus.out_nib !== second_nib(d)) begin errors++; $display("FAIL single_nib1 got %h want %h", bus.out_nib, second_nib(d)); end
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL single_last1 got %b want 1", bus.out_last); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", empty); end
    checks++; if (bytes_done !== 8'd1) begin errors++; $display("FAIL single_bytes_done got %0d want 1", bytes_done); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_seq [4];
    logic [7:0] done0;
    do_reset();
`ifdef UNPACK_LOW_FIRST_EN
    exp_seq = '{4'h2, 4'h1, 4'h4, 4'h3};
`else
    exp_seq = '{4'h1, 4'h2, 4'h3, 4'h4};
`endif
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h12;
    tick();
    bus.in_data   = 8'h34;
    tick();
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL bp_full got %b want 1", full); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
    bus.in_data = 8'h56;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.out_nib !== exp_seq[0] || bus.out_last !== 1'b0) begin errors++; $display("FAIL bp_hold nib %h last %b want %h 0", bus.out_nib, bus.out_last, exp_seq[0]); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    done0 = bytes_done;
    checks++; if (done0 !== 8'd0) begin errors++; $display("FAIL bp_done_start got %0d want 0", done0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_nib !== exp_seq[i]) begin errors++; $display("FAIL bp_seq%0d got %h valid %b want %h", i, bus.out_nib, bus.out_valid, exp_seq[i]); end
      tick();
    end
    checks++; if (bytes_done !== 8'd2) begin errors++; $display("FAIL bp_done_end got %0d want 2", bytes_done); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_empty got %b want 1 (stray byte accepted while full?)", empty); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_last !== 1'b1 || empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL pp_setup last %b empty %b full %b want 1 0 0", bus.out_last, empty, full); end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h7C;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL pp_in_ready got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL pp_count empty %b full %b want 0 0", empty, full); end
    checks++; if (bus.out_nib !== first_nib(8'h7C) || bus.out_last !== 1'b0) begin errors++; $display("FAIL pp_next nib %h last %b want %h 0", bus.out_nib, bus.out_last, first_nib(8'h7C)); end
    checks++; if (bytes_done !== 8'd1) begin errors++; $display("FAIL pp_done got %0d want 1", bytes_done); end
    tick();
    tick();
    checks++; if (empty !== 1'b1 || bytes_done !== 8'd2) begin errors++; $display("FAIL pp_drain empty %b done %0d want 1 2", empty, bytes_done); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_byte();
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hF0;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL mid_phase got %b want 1", bus.out_last); end
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bytes_done !== 8'd0) begin errors++; $display("FAIL mid_bytes_done got %0d want 0", bytes_done); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", empty); end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h9B;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_nib !== first_nib(8'h9B) || bus.out_last !== 1'b0) begin errors++; $display("FAIL mid_after nib %h last %b want %h 0", bus.out_nib, bus.out_last, first_nib(8'h9B)); end
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int accepted;
    int cyc;
    bit saw_zero_mid;
    do_reset();
    accepted      = 0;
    cyc           = 0;
    saw_zero_mid  = 0;
    bus.out_ready = 1'b1;
    while ((accepted < 256 || nib_q.size() > 0) && cyc < 2000) begin
      bus.in_valid = (accepted < 256);
      bus.in_data  = 8'($urandom);
      if (bus.in_valid && bus.in_ready) accepted++;
      checks++; if (bus.out_valid !== (nib_q.size() > 0)) begin errors++; $display("FAIL wrap_valid cyc %0d got %b want %b", cyc, bus.out_valid, nib_q.size() > 0); end
      if (nib_q.size() > 0) begin
        checks++; if (bus.out_nib !== nib_q[0]) begin errors++; $display("FAIL wrap_nib cyc %0d got %h want %h", cyc, bus.out_nib, nib_q[0]); end
      end
      if (cyc > 0 && accepted < 256 && nib_q.size() == 0) saw_zero_mid = 1;
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (cyc >= 2000) begin errors++; $display("FAIL wrap_timeout cycles %0d", cyc); end
    checks++; if (saw_zero_mid) begin errors++; $display("FAIL wrap_gap stream ran dry got 1 want 0"); end
    checks++; if (bytes_done !== 8'd0 || m_done !== 8'd0) begin errors++; $display("FAIL wrap_done got %0d want 0", bytes_done); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b want 1", empty); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 99) < 55);
      checks++; if (bus.in_ready !== (stored() < 2)) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", cyc, bus.in_ready, stored() < 2); end
      checks++; if (bus.out_valid !== (nib_q.size() > 0)) begin errors++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", cyc, bus.out_valid, nib_q.size() > 0); end
      checks++; if (full !== (stored() == 2) || empty !== (stored() == 0)) begin errors++; $display("FAIL rnd_flags cyc %0d full %b empty %b stored %0d", cyc, full, empty, stored()); end
      checks++; if (bytes_done !== m_done) begin errors++; $display("FAIL rnd_bytes_done cyc %0d got %0d want %0d", cyc, bytes_done, m_done); end
      if (nib_q.size() > 0) begin
        checks++; if (bus.out_nib !== nib_q[0] || bus.out_last !== (nib_q.size() % 2 == 1)) begin errors++; $display("FAIL rnd_nib cyc %0d got %h/%b want %h/%b", cyc, bus.out_nib, bus.out_last, nib_q[0], nib_q.size() % 2 == 1); end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst    = 1'b0;
    m_done = 8'd0;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_single_byte();
    test_backpressure();
    test_push_pop();
    test_reset_mid_byte();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_unpacker.md
BYTE_UNPACKER -- requirements
Module: byte_unpacker

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_data  input  8  byte to unpack.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 out_nib  output  4  current nibble.
REQ-008 out_valid  output  1  out_nib is valid.
REQ-009 out_ready  input  1  downstream accepts out_nib this cycle.
REQ-010 out_last  output  1  out_nib is the second nibble of its byte.
REQ-011 full  output  1  byte storage holds 2 bytes.
REQ-012 empty  output  1  byte storage holds 0 bytes.
REQ-013 bytes_done  output  8  count of fully emitted bytes; wraps modulo 256.

Function
REQ-014 The block SHALL store bytes in a 2-entry FIFO with a 2-bit occupancy count (0..2) and 1-bit read and write pointers.
REQ-015 in_ready SHALL equal (count < 2). A byte SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-016 out_valid SHALL equal (count > 0). out_nib, out_last and out_valid SHALL be derived only from registered state, with no combinational path from in_* to out_*.
REQ-017 Latency: a byte accepted into an empty block at edge N SHALL give out_valid=1 with its first nibble in the cycle after edge N.
REQ-018 The phase register (0 = first nibble, 1 = second nibble) SHALL drive out_last directly.
REQ-019 A nibble transfer SHALL occur when out_valid and out_ready are both 1. The phase SHALL then update as follows:
- phase 0: go to 1.
- phase 1: go to 0, pop the head byte, and increment bytes_done.
REQ-020 A push and a pop on the same edge SHALL leave count unchanged and advance both pointers.
REQ-021 When count=2, in_ready SHALL be 0 even if a pop occurs on the same edge; there is no pass-through.
REQ-022 While out_valid=1 and out_ready=0, out_nib and out_last SHALL hold stable.
REQ-023 bytes_done SHALL wrap from 255 to 0.
REQ-024 Status flags SHALL be full = (count==2) and empty = (count==0).
REQ-025 An in_valid that drops before acceptance SHALL have no effect.

Reset
REQ-026 When rst=1 at a rising edge, the following SHALL be cleared to 0: count, pointers, phase, both storage entries and bytes_done. This gives in_ready=1, out_valid=0, out_nib=0, out_last=0, full=0, empty=1 and bytes_done=0.
REQ-027 Reset SHALL take priority over any simultaneous push or pop.
REQ-028 Reset mid-byte SHALL discard any partially emitted byte without incrementing bytes_done.

Configuration
REQ-029 The macro UNPACK_LOW_FIRST_EN SHALL select the nibble order:
- defined: first nibble = in_data[3:0], second = in_data[7:4].
- undefined: first nibble = in_data[7:4], second = in_data[3:0].
All other behaviour SHALL be identical in both cases.

Verification
REQ-030 Single byte, default build: push 0xA5 with out_ready=1 held. Expect out_nib=0xA (out_last=0) then 0x5 (out_last=1), then empty=1 and bytes_done=1.
REQ-031 Same stimulus with UNPACK_LOW_FIRST_EN defined: push 0xA5. Expect 0x5 (out_last=0) then 0xA (out_last=1).
REQ-032 Backpressure: push 0x12 and 0x34 with out_ready=0. Expect full=1, in_ready=0, and out_nib=0x1 held stable. Then set out_ready=1 and expect 1,2,3,4 on consecutive cycles, with bytes_done going 0 to 2.
REQ-033 Simultaneous push and pop: with count=1 and phase=1, assert in_valid with 0x7C and out_ready=1 in the same cycle. Expect count to stay 1 and the next nibble to be 0x7 (default build).
REQ-034 Reset mid-byte: push 0xF0, take one nibble, assert rst for 1 cycle. Expect out_valid=0, bytes_done=0 and empty=1. Then push 0x9B and expect 0x9.
REQ-035 Wrap: stream 256 bytes continuously. Expect bytes_done to return to 0, with no gaps and out_valid never dropping while the FIFO is non-empty.
